// File: rtl/pb_intc_pkg.sv
// pb_intc_pkg
// Shared constants for the Picoblaze interrupt controller:
//   - I/O register offsets (low two bits of port_id inside the decoded block)
//   - FSM state encoding for the request/acknowledge/EOI sequencer
package pb_intc_pkg;

    // Register offsets from BASE_ADDR
    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_MASK   = 2'd1;
    localparam logic [1:0] REG_CLEAR  = 2'd2;
    localparam logic [1:0] REG_VECTOR = 2'd3;

    // Sequencer states
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] REQ     = 2'd1;
    localparam logic [1:0] SERVICE = 2'd2;

endpackage

// File: rtl/pb_intc_prio_enc.sv
// pb_intc_prio_enc
// Lowest-index-first priority encoder.
// Ports:
//   req        in  NUM_SRC  request vector
//   idx        out 3        index of the lowest set bit (0 when none set)
//   any_valid  out 1        at least one request bit is set
module pb_intc_prio_enc #(
    parameter int NUM_SRC = 8
) (
    input  logic [NUM_SRC-1:0] req,
    output logic [2:0]         idx,
    output logic               any_valid
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        idx = 3'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = 3'(i);
            end
        end
    end

    assign any_valid = |req;

endmodule

// File: rtl/pb_interrupt_controller.sv
// pb_interrupt_controller
// Interrupt controller between peripheral sources and the Picoblaze
// interrupt/interrupt_ack pins, with a small register file on the
// Picoblaze I/O port bus at BASE_ADDR+0..3:
//   +0 STATUS (R)  pending, zero-extended
//   +1 MASK   (RW) 1 = source enabled
//   +2 CLEAR  (W)  write-1-to-clear pending, reads 0
//   +3 VECTOR (R)  {vector_valid, 4'b0, vector[2:0]}; any write = EOI
// Ports:
//   CLK_IN        in  1        system clock
//   RESET_IN      in  1        synchronous active-low reset
//   irq_src       in  NUM_SRC  interrupt source lines (already synchronous)
//   port_id       in  8        CPU port address
//   out_port      in  8        CPU write data
//   write_strobe  in  1        CPU write strobe
//   read_strobe   in  1        CPU read strobe (reads have no side effects)
//   in_port       out 8        registered read data
//   interrupt     out 1        interrupt request to the CPU
//   interrupt_ack in  1        CPU acknowledge
// Build option:
//   PB_INTC_LEVEL_EN  defined: level-sensitive sources (pending follows
//                     irq_src, CLEAR and ack do not clear pending).
//                     undefined: rising-edge latched sources.
module pb_interrupt_controller
    import pb_intc_pkg::*;
#(
    parameter int         NUM_SRC   = 8,
    parameter logic [7:0] BASE_ADDR = 8'hF0
) (
    input  logic               CLK_IN,
    input  logic               RESET_IN,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [7:0]         port_id,
    input  logic [7:0]         out_port,
    input  logic               write_strobe,
    input  logic               read_strobe,
    output logic [7:0]         in_port,
    output logic               interrupt,
    input  logic               interrupt_ack
);

    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] active;
    logic [1:0]         state;
    logic [2:0]         vector;
    logic               vector_valid;
    logic [2:0]         prio_idx;
    logic               any_active;
    logic               addr_hit;
    logic [1:0]         reg_sel;
    logic               wr_mask;
    logic               wr_eoi;
    logic               ack_take;
    logic [7:0]         status_ext;
    logic [7:0]         mask_ext;
    logic [7:0]         rd_data;
    logic               unused_inputs;

    // read_strobe is informational and high out_port bits may be unused
    assign unused_inputs = ^{read_strobe, out_port};

    // BASE_ADDR is 4-aligned, so the block owns one port_id[7:2] value
    assign addr_hit = (port_id[7:2] == BASE_ADDR[7:2]);
    assign reg_sel  = port_id[1:0];
    assign wr_mask  = write_strobe && addr_hit && (reg_sel == REG_MASK);
    assign wr_eoi   = write_strobe && addr_hit && (reg_sel == REG_VECTOR);

    assign active = pending & mask;

    pb_intc_prio_enc #(
        .NUM_SRC (NUM_SRC)
    ) u_prio (
        .req       (active),
        .idx       (prio_idx),
        .any_valid (any_active)
    );

    // An ack only counts while a request is actually outstanding
    assign ack_take = (state == REQ) && interrupt_ack && any_active;

`ifdef PB_INTC_LEVEL_EN

    // Level mode: pending simply mirrors the source lines one clock later
    always_ff @(posedge CLK_IN) begin
        if (!RESET_IN) begin
            pending <= '0;
        end else begin
            pending <= irq_src;
        end
    end

`else

    logic [NUM_SRC-1:0] irq_prev;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] clr_bits;
    logic [NUM_SRC-1:0] ack_clr;
    logic               wr_clear;

    assign wr_clear = write_strobe && addr_hit && (reg_sel == REG_CLEAR);
    assign rise     = irq_src & ~irq_prev;
    assign clr_bits = wr_clear ? out_port[NUM_SRC-1:0] : '0;

    // One-hot of the source being acknowledged this cycle
    always_comb begin
        ack_clr = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (ack_take && (prio_idx == 3'(i))) begin
                ack_clr[i] = 1'b1;
            end
        end
    end

    // Edge mode: a new rising edge is OR-ed in after the clears so that a
    // simultaneous set always beats a CLEAR write or an ack clear.
    always_ff @(posedge CLK_IN) begin
        if (!RESET_IN) begin
            irq_prev <= '0;
            pending  <= '0;
        end else begin
            irq_prev <= irq_src;
            pending  <= (pending & ~clr_bits & ~ack_clr) | rise;
        end
    end

`endif

    always_ff @(posedge CLK_IN) begin
        if (!RESET_IN) begin
            mask <= '0;
        end else if (wr_mask) begin
            mask <= out_port[NUM_SRC-1:0];
        end
    end

    // Request sequencer. Losing all active sources in REQ cancels the
    // request even if an ack arrives in the same cycle, so a vector is
    // never latched for a source that was masked or cleared.
    always_ff @(posedge CLK_IN) begin
        if (!RESET_IN) begin
            state        <= IDLE;
            interrupt    <= 1'b0;
            vector       <= 3'd0;
            vector_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_active) begin
                        state     <= REQ;
                        interrupt <= 1'b1;
                    end
                end
                REQ: begin
                    if (!any_active) begin
                        state     <= IDLE;
                        interrupt <= 1'b0;
                    end else if (ack_take) begin
                        vector       <= prio_idx;
                        vector_valid <= 1'b1;
                        interrupt    <= 1'b0;
                        state        <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (wr_eoi) begin
                        vector_valid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    interrupt <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        status_ext                = '0;
        status_ext[NUM_SRC-1:0]   = pending;
        mask_ext                  = '0;
        mask_ext[NUM_SRC-1:0]     = mask;
    end

    always_comb begin
        rd_data = 8'h00;
        if (addr_hit) begin
            case (reg_sel)
                REG_STATUS: rd_data = status_ext;
                REG_MASK:   rd_data = mask_ext;
                REG_VECTOR: rd_data = {vector_valid, 4'b0000, vector};
                default:    rd_data = 8'h00;
            endcase
        end
    end

    // Registered every cycle so data is ready one clock after port_id
    always_ff @(posedge CLK_IN) begin
        if (!RESET_IN) begin
            in_port <= 8'h00;
        end else begin
            in_port <= rd_data;
        end
    end

endmodule

// File: tb/tb_pb_interrupt_controller.sv
// tb_pb_interrupt_controller
// Directed scoreboard bench for pb_interrupt_controller. Two instances share
// the CPU bus: dut8 (NUM_SRC=8) carries the functional tests, dut4
// (NUM_SRC=4, sources idle) covers bit-width truncation.
module tb_pb_interrupt_controller;

    localparam logic [7:0] A_STATUS = 8'hF0;
    localparam logic [7:0] A_MASK   = 8'hF1;
    localparam logic [7:0] A_CLEAR  = 8'hF2;
    localparam logic [7:0] A_VECTOR = 8'hF3;

    localparam int K_IN8  = 0;
    localparam int K_IN4  = 1;
    localparam int K_INT8 = 2;
    localparam int K_INT4 = 3;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] irq_src;
    logic [3:0] irq_src4;
    logic [7:0] port_id;
    logic [7:0] out_port;
    logic       write_strobe;
    logic       read_strobe;
    logic       interrupt_ack;
    logic [7:0] in_port8;
    logic [7:0] in_port4;
    logic       int8;
    logic       int4;

    int         cyc = 0;
    int         n_vec = 0;
    int         n_fail = 0;

    int         due_q[$];
    int         kind_q[$];
    logic [7:0] exp_q[$];
    string      name_q[$];
    logic [7:0] mon_act;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    pb_interrupt_controller #(
        .NUM_SRC   (8),
        .BASE_ADDR (8'hF0)
    ) dut8 (
        .CLK_IN        (clk),
        .RESET_IN      (reset_n),
        .irq_src       (irq_src),
        .port_id       (port_id),
        .out_port      (out_port),
        .write_strobe  (write_strobe),
        .read_strobe   (read_strobe),
        .in_port       (in_port8),
        .interrupt     (int8),
        .interrupt_ack (interrupt_ack)
    );

    pb_interrupt_controller #(
        .NUM_SRC   (4),
        .BASE_ADDR (8'hF0)
    ) dut4 (
        .CLK_IN        (clk),
        .RESET_IN      (reset_n),
        .irq_src       (irq_src4),
        .port_id       (port_id),
        .out_port      (out_port),
        .write_strobe  (write_strobe),
        .read_strobe   (read_strobe),
        .in_port       (in_port4),
        .interrupt     (int4),
        .interrupt_ack (interrupt_ack)
    );

    // Monitor: pops every expectation whose presentation cycle has arrived
    always @(negedge clk) begin
        while (due_q.size() > 0 && due_q[0] <= cyc) begin
            case (kind_q[0])
                K_IN8:   mon_act = in_port8;
                K_IN4:   mon_act = in_port4;
                K_INT8:  mon_act = {7'b0, int8};
                default: mon_act = {7'b0, int4};
            endcase
            n_vec++;
            if (due_q[0] < cyc || mon_act !== exp_q[0]) begin
                n_fail++;
                $display("[TB] FAIL %s: got 8'h%02h, expected 8'h%02h (cycle %0d)",
                         name_q[0], mon_act, exp_q[0], cyc);
            end
            void'(due_q.pop_front());
            void'(kind_q.pop_front());
            void'(exp_q.pop_front());
            void'(name_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle's worth of CPU bus signals
    task automatic applyStimulus(input logic [7:0] port, input logic [7:0] data,
                                 input logic wr, input logic rd);
        port_id      = port;
        out_port     = data;
        write_strobe = wr;
        read_strobe  = rd;
    endtask

    // Queue an expectation presented lat cycles from now
    task automatic checkOutput(input int kind, input logic [7:0] exp,
                               input string name, input int lat);
        due_q.push_back(cyc + lat);
        kind_q.push_back(kind);
        exp_q.push_back(exp);
        name_q.push_back(name);
    endtask

    task automatic write_reg(input logic [7:0] addr, input logic [7:0] data);
        applyStimulus(addr, data, 1'b1, 1'b0);
        tick();
        applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic read_reg(input logic [7:0] addr, input logic [7:0] exp,
                            input string name);
        applyStimulus(addr, 8'h00, 1'b0, 1'b1);
        checkOutput(K_IN8, exp, name, 1);
        tick();
        applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic read_both(input logic [7:0] addr, input logic [7:0] exp8,
                             input logic [7:0] exp4, input string name);
        applyStimulus(addr, 8'h00, 1'b0, 1'b1);
        checkOutput(K_IN8, exp8, name, 1);
        checkOutput(K_IN4, exp4, {name, "_n4"}, 1);
        tick();
        applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic expect_int(input logic exp, input string name);
        checkOutput(K_INT8, {7'b0, exp}, name, 0);
    endtask

    task automatic pulse_irq(input logic [7:0] bits);
        irq_src = bits;
        tick();
        irq_src = 8'h00;
    endtask

    task automatic pulse_ack();
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
    endtask

    initial begin
        reset_n       = 1'b0;
        irq_src       = 8'hFF;
        irq_src4      = 4'h0;
        interrupt_ack = 1'b0;
        applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);

        // Reset with all sources high; drop them as reset releases
        repeat (3) tick();
        expect_int(1'b0, "reset_int");
        reset_n = 1'b1;
        irq_src = 8'h00;
        tick();
        read_reg(A_STATUS, 8'h00, "reset_status");
        read_reg(A_MASK,   8'h00, "reset_mask");

        // Single event on source 2
        write_reg(A_MASK, 8'h04);
        pulse_irq(8'h04);
        expect_int(1'b0, "lat_n1");
        tick();
        expect_int(1'b1, "lat_n2");
        pulse_ack();
        expect_int(1'b0, "ack_drop");
        read_reg(A_VECTOR, 8'h82, "vec_after_ack");
        read_reg(A_STATUS, 8'h00, "status_after_ack");
        write_reg(A_VECTOR, 8'h00);
        read_reg(A_VECTOR, 8'h02, "vec_after_eoi");

        // Priority between sources 1 and 5
        write_reg(A_MASK, 8'hFF);
        pulse_irq(8'h22);
        tick();
        expect_int(1'b1, "prio_req1");
        pulse_ack();
        read_reg(A_VECTOR, 8'h81, "prio_vec1");
        read_reg(A_STATUS, 8'h20, "prio_status1");
        expect_int(1'b0, "svc_quiet");
        write_reg(A_VECTOR, 8'h00);
        tick();
        expect_int(1'b1, "prio_req2");
        pulse_ack();
        read_reg(A_VECTOR, 8'h85, "prio_vec2");
        write_reg(A_VECTOR, 8'h00);
        read_reg(A_STATUS, 8'h00, "prio_status2");

        // Ack while idle is ignored
        pulse_ack();
        read_reg(A_VECTOR, 8'h05, "idle_ack_ignored");

        // Reset in the middle of a request
        pulse_irq(8'h80);
        tick();
        expect_int(1'b1, "pre_reset_req");
        reset_n = 1'b0;
        tick();
        expect_int(1'b0, "reset_midop_int");
        reset_n = 1'b1;
        tick();
        read_reg(A_MASK,   8'h00, "reset_midop_mask");
        read_reg(A_VECTOR, 8'h00, "reset_midop_vec");
        read_reg(A_STATUS, 8'h00, "reset_midop_status");

        // Masked source, then unmask, then cancel by CLEAR
        pulse_irq(8'h08);
        tick();
        tick();
        expect_int(1'b0, "masked_quiet");
        read_reg(A_STATUS, 8'h08, "masked_pending");
        write_reg(A_MASK, 8'h08);
        tick();
        expect_int(1'b1, "unmask_req");
        write_reg(A_CLEAR, 8'h08);
        tick();
        expect_int(1'b0, "cancel_drop");
        read_reg(A_VECTOR, 8'h00, "cancel_vec");
        read_reg(A_STATUS, 8'h00, "cancel_status");

        // Edge and CLEAR of bit 0 in the same cycle: the set wins
        applyStimulus(A_CLEAR, 8'h01, 1'b1, 1'b0);
        irq_src = 8'h01;
        tick();
        irq_src = 8'h00;
        applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
        read_reg(A_STATUS, 8'h01, "set_beats_clear");
        write_reg(A_CLEAR, 8'h01);
        read_reg(A_STATUS, 8'h00, "clear_bit0");
        read_reg(A_CLEAR,  8'h00, "clear_reads_zero");

        // Address decode and source-count truncation
        read_reg(A_MASK, 8'h08, "mask_readback");
        read_reg(8'hEF,  8'h00, "unmapped_read");
        write_reg(A_MASK, 8'hFF);
        read_both(A_MASK, 8'hFF, 8'h0F, "mask_ff");
        write_reg(A_MASK, 8'h5A);
        read_both(A_MASK, 8'h5A, 8'h0A, "mask_5a");
        checkOutput(K_INT4, 8'h00, "int4_quiet", 0);

        repeat (3) tick();
        if (due_q.size() > 0) begin
            $display("[TB] FAIL pending_checks: got %0d unchecked, expected 0", due_q.size());
            n_fail += due_q.size();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
